// File: rtl/ifm_row_loader_pkg.sv
// Shared widths and FSM state encodings for the IFM row loader.
package ifm_row_loader_pkg;

  localparam int W_SIZE      = 12;
  localparam int W_CHANNEL   = 8;
  localparam int IFM_BUF_CNT = 4;
  localparam int W_IFM_BUF   = 2;
  localparam int W_BRAM_ADDR = 11;
  localparam int W_ADDR      = 32;
  localparam int W_LEN       = W_BRAM_ADDR + 1;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_CALC = 3'd1,
    S_REQ  = 3'd2,
    S_RECV = 3'd3,
    S_ZERO = 3'd4,
    S_DONE = 3'd5
  } state_e;

endpackage

// File: rtl/ifm_row_loader_if.sv
// DRAM burst-read port plus IFM buffer-bank write port of the row loader.
interface ifm_row_loader_if;
  import ifm_row_loader_pkg::*;

  logic                   o_rd_req;
  logic [W_ADDR-1:0]      o_rd_addr;
  logic [W_LEN-1:0]       o_rd_len;
  logic                   i_rd_ack;
  logic [31:0]            i_rd_data;
  logic                   i_rd_valid;
  logic                   o_rd_ready;
  logic                   o_bram_we;
  logic [W_IFM_BUF-1:0]   o_bram_sel;
  logic [W_BRAM_ADDR-1:0] o_bram_addr;
  logic [63:0]            o_bram_wdata;

  modport master (
    output o_rd_req, o_rd_addr, o_rd_len, o_rd_ready,
    output o_bram_we, o_bram_sel, o_bram_addr, o_bram_wdata,
    input  i_rd_ack, i_rd_data, i_rd_valid
  );

  modport slave (
    input  o_rd_req, o_rd_addr, o_rd_len, o_rd_ready,
    input  o_bram_we, o_bram_sel, o_bram_addr, o_bram_wdata,
    output i_rd_ack, i_rd_data, i_rd_valid
  );

endinterface

// File: rtl/ifm_row_loader_packer.sv
// ifm_beat_packer: pairs 32-bit beats into 64-bit words (first beat low) and
// produces the buffer write strobe and word index. i_fill writes zero words
// at successive indices for padding rows.
module ifm_beat_packer
  import ifm_row_loader_pkg::*;
(
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   i_clr,
  input  logic                   i_beat_vld,
  input  logic [31:0]            i_beat_data,
  input  logic                   i_fill,
  output logic                   o_we,
  output logic [W_BRAM_ADDR-1:0] o_addr,
  output logic [63:0]            o_wdata
);

  logic                   phase_q, phase_d;
  logic [31:0]            low_q, low_d;
  logic [W_BRAM_ADDR-1:0] idx_q, idx_d;

  // Pack/advance logic; the odd beat writes in the same cycle it arrives.
  always_comb begin
    phase_d = phase_q;
    low_d   = low_q;
    idx_d   = idx_q;
    o_we    = 1'b0;
    o_wdata = '0;
    if (i_clr) begin
      phase_d = 1'b0;
      low_d   = '0;
      idx_d   = '0;
    end else if (i_fill) begin
      o_we  = 1'b1;
      idx_d = idx_q + W_BRAM_ADDR'(1);
    end else if (i_beat_vld) begin
      if (!phase_q) begin
        low_d   = i_beat_data;
        phase_d = 1'b1;
      end else begin
        o_we    = 1'b1;
        o_wdata = {i_beat_data, low_q};
        phase_d = 1'b0;
        idx_d   = idx_q + W_BRAM_ADDR'(1);
      end
    end
  end

  assign o_addr = idx_q;

  // Pack register, beat phase and word index (reset is active-high).
  always_ff @(posedge clk) begin
    if (rstn) begin
      phase_q <= 1'b0;
      low_q   <= '0;
      idx_q   <= '0;
    end else begin
      phase_q <= phase_d;
      low_q   <= low_d;
      idx_q   <= idx_d;
    end
  end

endmodule

// File: rtl/ifm_row_loader.sv
// IFM row loader: fetches one IFM row (width*channel 64-bit words) from DRAM
// as 32-bit beats and writes it into ring slot row mod IFM_BUF_CNT, or fills
// the slot with zeros for padding rows (row >= height).
// Optional macro IFM_ROW_LOADER_PERF_EN enables the o_stall_cnt counter.
//
// state | meaning
// IDLE  | waiting for i_req_load
// CALC  | latch word count and DRAM start address
// REQ   | burst request held until i_rd_ack
// RECV  | accepting beats, writing packed words
// ZERO  | writing zero words for a padding row
// DONE  | one-cycle done pulse
module ifm_row_loader
  import ifm_row_loader_pkg::*;
(
  input  logic                 clk,
  input  logic                 rstn,
  input  logic [W_ADDR-1:0]    q_base_addr,
  input  logic [W_SIZE-1:0]    q_width,
  input  logic [W_SIZE-1:0]    q_height,
  input  logic [W_CHANNEL-1:0] q_channel,
  input  logic                 i_req_load,
  input  logic [W_SIZE-1:0]    i_req_row,
  output logic                 o_buf_done,
  output logic                 o_busy,
  output logic [31:0]          o_stall_cnt,
  ifm_row_loader_if.master     bus
);

  state_e              state_q, state_d;
  logic [W_SIZE-1:0]   row_q, row_d;
  logic [W_LEN-1:0]    words_q, words_d;
  logic [W_ADDR-1:0]   addr_q, addr_d;

  logic [W_LEN-1:0]       words_calc;
  logic [W_ADDR-1:0]      addr_calc;
  logic                   pk_clr, pk_fill, beat_vld, pk_we, last_word;
  logic [W_BRAM_ADDR-1:0] pk_addr;
  logic [63:0]            pk_wdata;

  assign words_calc = W_LEN'(q_width * W_SIZE'(q_channel));
  assign addr_calc  = q_base_addr + ((W_ADDR'(row_q) * W_ADDR'(words_calc)) << 3);

  assign pk_clr    = (state_q == S_IDLE);
  assign pk_fill   = (state_q == S_ZERO) && (words_q != '0);
  assign beat_vld  = (state_q == S_RECV) && bus.i_rd_valid;
  assign last_word = ({1'b0, pk_addr} == (words_q - W_LEN'(1)));

  ifm_beat_packer u_packer (
    .clk         (clk),
    .rstn        (rstn),
    .i_clr       (pk_clr),
    .i_beat_vld  (beat_vld),
    .i_beat_data (bus.i_rd_data),
    .i_fill      (pk_fill),
    .o_we        (pk_we),
    .o_addr      (pk_addr),
    .o_wdata     (pk_wdata)
  );

  // Next-state and load bookkeeping; config is sampled entering CALC/ZERO.
  always_comb begin
    state_d    = state_q;
    row_d      = row_q;
    words_d    = words_q;
    addr_d     = addr_q;
    o_busy     = 1'b0;
    o_buf_done = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (i_req_load) begin
          row_d = i_req_row;
          if (i_req_row < q_height) begin
            state_d = S_CALC;
          end else begin
            words_d = words_calc;
            state_d = S_ZERO;
          end
        end
      end
      S_CALC: begin
        o_busy  = 1'b1;
        words_d = words_calc;
        addr_d  = addr_calc;
        state_d = (words_calc == '0) ? S_DONE : S_REQ;
      end
      S_REQ: begin
        o_busy = 1'b1;
        if (bus.i_rd_ack) state_d = S_RECV;
      end
      S_RECV: begin
        o_busy = 1'b1;
        if (pk_we && last_word) state_d = S_DONE;
      end
      S_ZERO: begin
        o_busy = 1'b1;
        if (words_q == '0 || last_word) state_d = S_DONE;
      end
      S_DONE: begin
        o_buf_done = 1'b1;
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FSM state and latched load parameters.
  always_ff @(posedge clk) begin
    if (rstn) begin
      state_q <= S_IDLE;
      row_q   <= '0;
      words_q <= '0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      words_q <= words_d;
      addr_q  <= addr_d;
    end
  end

  assign bus.o_rd_req     = (state_q == S_REQ);
  assign bus.o_rd_addr    = (state_q == S_REQ) ? addr_q : '0;
  assign bus.o_rd_len     = (state_q == S_REQ) ? {words_q[W_LEN-2:0], 1'b0} : '0;
  assign bus.o_rd_ready   = (state_q == S_RECV);
  assign bus.o_bram_we    = pk_we;
  assign bus.o_bram_sel   = row_q[W_IFM_BUF-1:0];
  assign bus.o_bram_addr  = pk_addr;
  assign bus.o_bram_wdata = pk_wdata;

`ifdef IFM_ROW_LOADER_PERF_EN
  logic [31:0] stall_q, stall_d;

  // Saturating count of cycles stalled on ack or beat valid.
  always_comb begin
    stall_d = stall_q;
    if ((stall_q != '1) &&
        (((state_q == S_REQ) && !bus.i_rd_ack) ||
         ((state_q == S_RECV) && !bus.i_rd_valid)))
      stall_d = stall_q + 32'd1;
  end

  // Stall counter register, cleared only by reset.
  always_ff @(posedge clk) begin
    if (rstn) stall_q <= '0;
    else      stall_q <= stall_d;
  end

  assign o_stall_cnt = stall_q;
`else
  assign o_stall_cnt = '0;
`endif

endmodule

// File: tb/tb_ifm_row_loader.sv
// Directed bench for ifm_row_loader: acts as DRAM responder, records buffer
// writes and done pulses, and checks them against hand-computed values.
module tb_ifm_row_loader;

  logic        clk;
  logic        rstn;
  logic [31:0] q_base_addr;
  logic [11:0] q_width, q_height;
  logic [7:0]  q_channel;
  logic        i_req_load;
  logic [11:0] i_req_row;
  logic        o_buf_done, o_busy;
  logic [31:0] o_stall_cnt;

  ifm_row_loader_if bus();

  ifm_row_loader dut (
    .clk         (clk),
    .rstn        (rstn),
    .q_base_addr (q_base_addr),
    .q_width     (q_width),
    .q_height    (q_height),
    .q_channel   (q_channel),
    .i_req_load  (i_req_load),
    .i_req_row   (i_req_row),
    .o_buf_done  (o_buf_done),
    .o_busy      (o_busy),
    .o_stall_cnt (o_stall_cnt),
    .bus         (bus)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int c0 = 0;
  int exp_words = 0;

  int          wr_cnt, done_cnt, done_cyc, last_wr_cyc, req_cyc_cnt, ack_cnt;
  logic        busy_at_done;
  logic [31:0] rd_addr_s;
  logic [11:0] rd_len_s;
  logic [10:0] wr_addr [2048];
  logic [63:0] wr_data [2048];
  logic [1:0]  wr_sel  [2048];

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (bus.o_bram_we) begin
      if (wr_cnt < 2048) begin
        wr_addr[wr_cnt] = bus.o_bram_addr;
        wr_data[wr_cnt] = bus.o_bram_wdata;
        wr_sel[wr_cnt]  = bus.o_bram_sel;
      end
      wr_cnt++;
      last_wr_cyc = cyc;
    end
    if (o_buf_done) begin
      done_cnt++;
      done_cyc = cyc;
      busy_at_done = o_busy;
    end
    if (bus.o_rd_req) begin
      req_cyc_cnt++;
      rd_addr_s = bus.o_rd_addr;
      rd_len_s  = bus.o_rd_len;
      if (bus.i_rd_ack) ack_cnt++;
    end
  end

  function automatic logic [31:0] beat_val(input int k);
    if (k == 0) return 32'h1111_1111;
    if (k == 1) return 32'h2222_2222;
    return 32'hA500_0000 | 32'(k);
  endfunction

  function automatic logic [63:0] exp_word(input int j);
    return {beat_val(2 * j + 1), beat_val(2 * j)};
  endfunction

  task automatic clr_mon();
    wr_cnt = 0; done_cnt = 0; done_cyc = 0; last_wr_cyc = 0;
    req_cyc_cnt = 0; ack_cnt = 0; busy_at_done = 1'bx;
    rd_addr_s = '0; rd_len_s = '0;
  endtask

  // Issues one request and plays the DRAM side until done (or reset injection).
  task automatic run_load(input logic [11:0] row, input int ack_dly, input bit toggle,
                          input int ovl_at, input int rst_at, input int budget);
    int k, nreq, nrcv, t;
    bit fin, ok;
    k = 0; nreq = 0; nrcv = 0; t = 0; fin = 0; ok = 0;
    clr_mon();
    @(posedge clk); #1;
    i_req_load = 1'b1; i_req_row = row; c0 = cyc;
    @(posedge clk); #1;
    i_req_load = 1'b0;
    while (!fin) begin
      bus.i_rd_ack = 1'b0; bus.i_rd_valid = 1'b0; bus.i_rd_data = 32'hDEAD_BEEF;
      if (done_cnt != 0) begin
        fin = 1; ok = 1;
      end else if (t >= budget) begin
        fin = 1;
      end else if (rst_at >= 0 && k == rst_at) begin
        rstn = 1'b1;
        @(posedge clk); #1;
        rstn = 1'b0;
        fin = 1; ok = 1;
      end else begin
        if (bus.o_rd_req) begin
          if (nreq >= ack_dly) bus.i_rd_ack = 1'b1;
          nreq++;
        end else if (bus.o_rd_ready) begin
          if ((!toggle || (nrcv % 2 == 0)) && k < 2 * exp_words) begin
            bus.i_rd_valid = 1'b1;
            bus.i_rd_data  = beat_val(k);
            k++;
          end
          nrcv++;
          if (ovl_at >= 0 && k == ovl_at) begin
            i_req_load = 1'b1; i_req_row = row + 12'd5;
          end
        end
        @(posedge clk); #1;
        i_req_load = 1'b0;
        t++;
      end
    end
    bus.i_rd_ack = 1'b0; bus.i_rd_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL run_load_timeout: row=%0d no done after %0d cycles", row, budget);
    end
  endtask

  task automatic chk_words(input string name, input int n, input logic [1:0] sel, input bit zero);
    int bad, first;
    logic [63:0] ew;
    bad = 0; first = -1;
    for (int j = 0; j < n; j++) begin
      ew = zero ? 64'h0 : exp_word(j);
      if (wr_addr[j] !== 11'(j) || wr_data[j] !== ew || wr_sel[j] !== sel) begin
        if (bad == 0) first = j;
        bad++;
      end
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL %s_words: %0d bad, first idx %0d addr=%0d data=%h sel=%0d (expected sel %0d)",
               name, bad, first, wr_addr[first], wr_data[first], wr_sel[first], sel);
    end
  endtask

  task automatic test_reset();
    rstn = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rstn = 1'b0;
    #1;
    checks++;
    if ({o_buf_done, o_busy, bus.o_rd_req, bus.o_rd_ready, bus.o_bram_we} !== 5'b0) begin
      errors++;
      $display("FAIL reset_ctrl: done/busy/req/ready/we=%b expected 00000",
               {o_buf_done, o_busy, bus.o_rd_req, bus.o_rd_ready, bus.o_bram_we});
    end
    checks++;
    if ({bus.o_rd_addr, bus.o_rd_len, bus.o_bram_sel, bus.o_bram_addr, bus.o_bram_wdata, o_stall_cnt} !== '0) begin
      errors++;
      $display("FAIL reset_data: addr=%h len=%0d sel=%0d baddr=%0d wdata=%h stall=%0d expected all 0",
               bus.o_rd_addr, bus.o_rd_len, bus.o_bram_sel, bus.o_bram_addr, bus.o_bram_wdata, o_stall_cnt);
    end
  endtask

  task automatic test_row_request();
    exp_words = 1024;
    run_load(12'd5, 0, 1'b0, -1, -1, 3000);
    checks++;
    if (rd_addr_s !== 32'h0000_B000) begin
      errors++; $display("FAIL row_rd_addr: got %h expected 0000b000", rd_addr_s);
    end
    checks++;
    if (rd_len_s !== 12'd2048) begin
      errors++; $display("FAIL row_rd_len: got %0d expected 2048", rd_len_s);
    end
    checks++;
    if (wr_cnt !== 1024) begin
      errors++; $display("FAIL row_wr_cnt: got %0d expected 1024", wr_cnt);
    end
    chk_words("row", 1024, 2'd1, 1'b0);
    checks++;
    if (done_cnt !== 1 || done_cyc - c0 !== 3 + 2048 || done_cyc !== last_wr_cyc + 1) begin
      errors++;
      $display("FAIL row_done: pulses=%0d latency=%0d last_wr_gap=%0d expected 1, 2051, 1",
               done_cnt, done_cyc - c0, done_cyc - last_wr_cyc);
    end
    checks++;
    if (busy_at_done !== 1'b0 || req_cyc_cnt !== 1) begin
      errors++;
      $display("FAIL row_busy_req: busy_at_done=%b req_cycles=%0d expected 0, 1", busy_at_done, req_cyc_cnt);
    end
  endtask

  task automatic test_beat_packing();
    q_width = 12'd2; q_channel = 8'd1;
    exp_words = 2;
    run_load(12'd2, 0, 1'b0, -1, -1, 100);
    checks++;
    if (wr_data[0] !== 64'h2222_2222_1111_1111 || wr_addr[0] !== 11'd0) begin
      errors++;
      $display("FAIL pack_first: data=%h addr=%0d expected 2222222211111111 at 0", wr_data[0], wr_addr[0]);
    end
    checks++;
    if (rd_addr_s !== 32'h0000_1020 || rd_len_s !== 12'd4 || wr_cnt !== 2) begin
      errors++;
      $display("FAIL pack_small: addr=%h len=%0d writes=%0d expected 00001020, 4, 2", rd_addr_s, rd_len_s, wr_cnt);
    end
    chk_words("pack", 2, 2'd2, 1'b0);
    q_width = 12'd256; q_channel = 8'd4;
  endtask

  task automatic test_padding();
    exp_words = 1024;
    run_load(12'd256, 0, 1'b0, -1, -1, 1500);
    checks++;
    if (req_cyc_cnt !== 0 || wr_cnt !== 1024) begin
      errors++;
      $display("FAIL pad_counts: req_cycles=%0d writes=%0d expected 0, 1024", req_cyc_cnt, wr_cnt);
    end
    chk_words("pad", 1024, 2'd0, 1'b1);
    checks++;
    if (done_cnt !== 1 || done_cyc - c0 !== 1025) begin
      errors++;
      $display("FAIL pad_done: pulses=%0d latency=%0d expected 1, 1025", done_cnt, done_cyc - c0);
    end
  endtask

  task automatic test_zero_words();
    q_channel = 8'd0;
    exp_words = 0;
    run_load(12'd3, 0, 1'b0, -1, -1, 50);
    checks++;
    if (wr_cnt !== 0 || req_cyc_cnt !== 0 || done_cnt !== 1 || done_cyc - c0 !== 2) begin
      errors++;
      $display("FAIL zero_words: writes=%0d req=%0d pulses=%0d latency=%0d expected 0, 0, 1, 2",
               wr_cnt, req_cyc_cnt, done_cnt, done_cyc - c0);
    end
    q_channel = 8'd4;
  endtask

  task automatic test_backpressure();
    logic [31:0] exp_stall;
    rstn = 1'b1;
    @(posedge clk); #1;
    rstn = 1'b0;
    exp_words = 1024;
    run_load(12'd5, 7, 1'b1, -1, -1, 6000);
`ifdef IFM_ROW_LOADER_PERF_EN
    exp_stall = 32'd2054;
`else
    exp_stall = 32'd0;
`endif
    checks++;
    if (wr_cnt !== 1024 || req_cyc_cnt !== 8 || rd_addr_s !== 32'h0000_B000) begin
      errors++;
      $display("FAIL bp_counts: writes=%0d req_cycles=%0d addr=%h expected 1024, 8, 0000b000",
               wr_cnt, req_cyc_cnt, rd_addr_s);
    end
    chk_words("bp", 1024, 2'd1, 1'b0);
    checks++;
    if (done_cnt !== 1 || done_cyc - c0 !== 4105) begin
      errors++;
      $display("FAIL bp_done: pulses=%0d latency=%0d expected 1, 4105", done_cnt, done_cyc - c0);
    end
    checks++;
    if (o_stall_cnt !== exp_stall) begin
      errors++;
      $display("FAIL bp_stall: got %0d expected %0d", o_stall_cnt, exp_stall);
    end
  endtask

  task automatic test_overlap();
    q_width = 12'd8; q_channel = 8'd1;
    exp_words = 8;
    run_load(12'd1, 0, 1'b0, 6, -1, 100);
    checks++;
    if (done_cnt !== 1 || ack_cnt !== 1 || wr_cnt !== 8 || rd_addr_s !== 32'h0000_1040) begin
      errors++;
      $display("FAIL overlap: pulses=%0d acks=%0d writes=%0d addr=%h expected 1, 1, 8, 00001040",
               done_cnt, ack_cnt, wr_cnt, rd_addr_s);
    end
    chk_words("overlap", 8, 2'd1, 1'b0);
    checks++;
    if (o_busy !== 1'b0 || bus.o_rd_req !== 1'b0) begin
      errors++;
      $display("FAIL overlap_idle: busy=%b req=%b expected 0, 0", o_busy, bus.o_rd_req);
    end
  endtask

  task automatic test_reset_mid();
    exp_words = 8;
    run_load(12'd3, 0, 1'b0, -1, 5, 100);
    checks++;
    if ({o_buf_done, o_busy, bus.o_rd_req, bus.o_rd_ready, bus.o_bram_we} !== 5'b0 ||
        bus.o_bram_sel !== 2'd0 || bus.o_bram_addr !== 11'd0 || o_stall_cnt !== 32'd0) begin
      errors++;
      $display("FAIL rst_mid_outputs: ctrl=%b sel=%0d baddr=%0d stall=%0d expected all 0",
               {o_buf_done, o_busy, bus.o_rd_req, bus.o_rd_ready, bus.o_bram_we},
               bus.o_bram_sel, bus.o_bram_addr, o_stall_cnt);
    end
    checks++;
    if (done_cnt !== 0) begin
      errors++; $display("FAIL rst_mid_done: pulses=%0d expected 0", done_cnt);
    end
    run_load(12'd2, 0, 1'b0, -1, -1, 100);
    checks++;
    if (done_cnt !== 1 || wr_cnt !== 8 || rd_addr_s !== 32'h0000_1080 || done_cyc - c0 !== 19) begin
      errors++;
      $display("FAIL rst_mid_next: pulses=%0d writes=%0d addr=%h latency=%0d expected 1, 8, 00001080, 19",
               done_cnt, wr_cnt, rd_addr_s, done_cyc - c0);
    end
    chk_words("rst_next", 8, 2'd2, 1'b0);
  endtask

  initial begin
    rstn = 1'b1;
    q_base_addr = 32'h0000_1000;
    q_width = 12'd256; q_height = 12'd256; q_channel = 8'd4;
    i_req_load = 1'b0; i_req_row = '0;
    bus.i_rd_ack = 1'b0; bus.i_rd_valid = 1'b0; bus.i_rd_data = '0;
    clr_mon();
    test_reset();
    test_row_request();
    test_beat_packing();
    test_padding();
    test_zero_words();
    test_backpressure();
    test_overlap();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ifm_row_loader.md
Name: ifm_row_loader

Overview:
- Upstream feeder of the CNN controller's IFM buffer bank.
- On each row-load request from the controller it fetches one IFM row from DRAM over a simple burst-read port: all tiled channels of that row, width*channel 64-bit words.
- Each word arrives as two 32-bit beats. The block packs beat pairs into 64-bit words and writes them into ring slot (row mod IFM_BUF_CNT) of the buffer bank.
- It pulses the done signal that the controller consumes as q_ifm_buf_done.

Parameters:
- W_SIZE, 12, width/height/row field width
- W_CHANNEL, 8, tiled-channel count width
- IFM_BUF_CNT, 4, number of row slots in the buffer bank
- W_IFM_BUF, 2, log2(IFM_BUF_CNT)
- W_BRAM_ADDR, 11, word address inside one slot (max 2048 words)
- W_ADDR, 32, DRAM byte address width

Ports:
- clk  in  1  clock
- rstn  in  1  reset; synchronous, active-high (1 = reset)
- q_base_addr  in  W_ADDR  DRAM byte address of row 0 (8-byte aligned)
- q_width  in  W_SIZE  row width in pixels
- q_height  in  W_SIZE  frame height
- q_channel  in  W_CHANNEL  tiled channel count
- i_req_load  in  1  load request from controller
- i_req_row  in  W_SIZE  row index to load
- o_buf_done  out  1  one-cycle pulse; row fully written
- o_busy  out  1  load in progress
- o_rd_req  out  1  burst request valid
- o_rd_addr  out  W_ADDR  burst start byte address
- o_rd_len  out  W_BRAM_ADDR+1  burst length in 32-bit beats
- i_rd_ack  in  1  burst request accepted
- i_rd_data  in  32  read beat
- i_rd_valid  in  1  beat valid
- o_rd_ready  out  1  beat accept
- o_bram_we  out  1  buffer write enable
- o_bram_sel  out  W_IFM_BUF  target slot
- o_bram_addr  out  W_BRAM_ADDR  word address
- o_bram_wdata  out  64  packed word, first beat in bits [31:0]
- o_stall_cnt  out  32  perf counter (see optional feature)

Behaviour:
- Reset: all outputs 0; FSM in IDLE; pack register cleared.
- The reset clears everything in-flight with no done pulse. DRAM-side cleanup is the interconnect's responsibility.
- FSM states: IDLE, CALC, REQ, RECV, ZERO, DONE.
- IDLE:
  - i_req_load=1 latches i_req_row; o_busy=1 from the next cycle.
  - If row < q_height, go to CALC; otherwise go to ZERO (padding row).
- CALC (1 cycle):
  - words = q_width*q_channel, truncated to W_BRAM_ADDR+1 bits.
  - addr = q_base_addr + row*words*8, W_ADDR bits, wrap-around on overflow.
  - Go to REQ.
- REQ:
  - o_rd_req=1 and held with addr/len stable until i_rd_ack, where len = 2*words.
  - Go to RECV on the ack cycle.
- RECV:
  - o_rd_ready=1.
  - Even beat: stored into the low half of the pack register.
  - Odd beat: o_bram_we=1 that same cycle with {beat, low}, o_bram_addr=word index, then the word index increments.
  - Final word written: go to DONE.
- ZERO:
  - Writes 64'h0 to every word address 0..words-1, one per cycle.
  - No DRAM access.
  - Then go to DONE.
- DONE (1 cycle):
  - o_buf_done=1 and o_busy=0 in that cycle. Return to IDLE.
  - A new request is accepted in IDLE the following cycle.
- o_bram_sel = latched row[W_IFM_BUF-1:0], held for the whole load.
- Latency: request to done = 3 + ack wait + 2*words beat cycles (+ valid gaps).
- i_req_load while o_busy (or in DONE) is ignored.
- words==0 (width or channel 0): skip the fetch and go straight to DONE; no BRAM writes.
- i_rd_valid outside RECV is ignored.
- Configuration inputs are sampled only in CALC/ZERO entry. Changes mid-load have no effect.

Optional Feature:
- Macro IFM_ROW_LOADER_PERF_EN.
- Defined: o_stall_cnt counts cycles in REQ with i_rd_ack=0 plus cycles in RECV with i_rd_valid=0. Saturates at 2^32-1; cleared only by reset.
- Undefined: o_stall_cnt tied to 0 and no counter logic.

Decomposition:
- Shared package/header (controller_params.vh): W_SIZE, W_CHANNEL, IFM_BUF_CNT, W_IFM_BUF, W_BRAM_ADDR, and the FSM state encodings.
- One natural sub-module, ifm_beat_packer: the 32-to-64 pair packer that emits the write strobe and word index.

Test Plan:
- Row request: width=256, channel=4, row=5, base=0x1000.
  - o_rd_addr=0x1000+5*8192=0xB000, o_rd_len=2048.
  - 1024 writes, addr 0..1023, sel=1.
  - One done pulse after the last write (2048 beats with valid always 1).
- Beat packing: beats 0x11111111, 0x22222222 → first write data 0x22222222_11111111 at addr 0.
- Padding row: row=256, height=256.
  - No o_rd_req.
  - 1024 zero writes to sel=0, then done.
- Backpressure: ack delayed 7 cycles and valid toggling 1/0 → same write data/addresses; done delayed accordingly. With PERF_EN, o_stall_cnt=7+2047.
- Overlapping request: second i_req_load mid-RECV is ignored; exactly one done pulse.
- Reset mid-RECV: rstn=1 for 1 cycle → all outputs 0, no done pulse; next request completes normally.
